cache_line_fill: RTL and testbench

CACHE_LINE_FILL -- requirements
Module: cache_line_fill

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_line_fill_if.sv | 41 ++++
 rtl/fill_byte_packer.sv | 42 ++++
 rtl/cache_line_fill.sv | 122 ++++++++++++
 tb/tb_cache_line_fill.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-fill block: fill FSM states and
// default data-RAM geometry with the derived line-index / word-offset widths.
package cache_pkg;

  localparam int CACHE_ADDR_W     = 10;
  localparam int CACHE_LINE_WORDS = 8;
  localparam int CACHE_OFF_W      = $clog2(CACHE_LINE_WORDS);
  localparam int CACHE_LINE_W     = CACHE_ADDR_W - CACHE_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/cache_line_fill_if.sv
// Bus bundle of the cache line-fill block: fill request, SPI byte stream,
// word read port and registered data-RAM port.
interface cache_line_fill_if
  import cache_pkg::*;
#(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int LINE_WORDS = CACHE_LINE_WORDS
);
  localparam int LINE_W = ADDR_W - $clog2(LINE_WORDS);

  logic              fill_req_i;
  logic [LINE_W-1:0] fill_line_i;
  logic              fill_ack_o;
  logic              fill_done_o;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_gnt_o;
  logic              rd_valid_o;
  logic [31:0]       rd_data_o;
  logic              ram_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_di_o;
  logic [3:0]        ram_we_o;
  logic [31:0]       ram_do_i;

  modport slave (
    input  fill_req_i, fill_line_i, byte_valid_i, byte_data_i, rd_req_i, rd_addr_i, ram_do_i,
    output fill_ack_o, fill_done_o, byte_ready_o, rd_gnt_o, rd_valid_o, rd_data_o,
           ram_en_o, ram_addr_o, ram_di_o, ram_we_o
  );

  modport master (
    output fill_req_i, fill_line_i, byte_valid_i, byte_data_i, rd_req_i, rd_addr_i, ram_do_i,
    input  fill_ack_o, fill_done_o, byte_ready_o, rd_gnt_o, rd_valid_o, rd_data_o,
           ram_en_o, ram_addr_o, ram_di_o, ram_we_o
  );

endinterface

// File: rtl/fill_byte_packer.sv
// Assembles four accepted bytes into a 32-bit word and strobes on the fourth.
// Little-endian by default; CACHE_FILL_BSWAP_EN selects big-endian packing.
module fill_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_acc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] sr_q;

  // word_o already includes the byte being accepted, so the final byte of a
  // word can be written to RAM on the very next edge.
`ifdef CACHE_FILL_BSWAP_EN
  assign word_o = {sr_q[23:0], byte_i};
`else
  assign word_o = {byte_i, sr_q[31:8]};
`endif

  assign word_done_o = byte_acc_i && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q <= 2'd0;
    end else if (clr_i) begin
      byte_cnt_q <= 2'd0;
    end else if (byte_acc_i) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (byte_acc_i) begin
      sr_q <= word_o;
    end
  end

endmodule

// File: rtl/cache_line_fill.sv
// Cache line fill from an SPI byte stream into a data RAM, sharing the RAM
// port with a 2-cycle word read path. CACHE_FILL_BSWAP_EN: big-endian packing.
module cache_line_fill
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  parameter int ADDR_W     = CACHE_ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cache_line_fill_if.slave bus
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;

  fill_state_e       state_q, state_d;
  logic [LINE_W-1:0] line_q;
  logic [OFF_W-1:0]  word_cnt_q;
  logic              fill_acc, rd_acc, byte_acc, word_done;
  logic [31:0]       word;

  logic              rd_vld_p1, rd_vld_p2, wr_vld_p1;
  logic              ram_en_q;
  logic [3:0]        ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_di_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill wins over a simultaneous read; the line completes one cycle after
  // its last word write has been issued.
  always_comb begin
    state_d  = state_q;
    fill_acc = 1'b0;
    rd_acc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.fill_req_i) begin
          fill_acc = 1'b1;
          state_d  = ST_FILL;
        end else begin
          rd_acc = bus.rd_req_i;
        end
      end
      ST_FILL: begin
        if (wr_vld_p1 && (word_cnt_q == OFF_W'(LINE_WORDS - 1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_acc         = (state_q == ST_FILL) && bus.byte_valid_i;
  assign bus.fill_ack_o   = fill_acc & ~rst_i;
  assign bus.rd_gnt_o     = rd_acc & ~rst_i;
  assign bus.byte_ready_o = (state_q == ST_FILL);
  assign bus.fill_done_o  = (state_q == ST_DONE);

  fill_byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (fill_acc),
    .byte_acc_i  (byte_acc),
    .byte_i      (bus.byte_data_i),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q     <= '0;
      word_cnt_q <= '0;
    end else if (fill_acc) begin
      line_q     <= bus.fill_line_i;
      word_cnt_q <= '0;
    end else if (wr_vld_p1) begin
      word_cnt_q <= word_cnt_q + OFF_W'(1);
    end
  end

  // p1: RAM access issued (read or write); p2: read data returned by the RAM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_p1  <= 1'b0;
      rd_vld_p2  <= 1'b0;
      wr_vld_p1  <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 4'h0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
    end else begin
      rd_vld_p1 <= rd_acc;
      rd_vld_p2 <= rd_vld_p1;
      wr_vld_p1 <= word_done;
      ram_en_q  <= rd_acc | word_done;
      ram_we_q  <= word_done ? 4'hF : 4'h0;
      if (rd_acc) begin
        ram_addr_q <= bus.rd_addr_i;
      end else if (word_done) begin
        ram_addr_q <= {line_q, word_cnt_q};
        ram_di_q   <= word;
      end
    end
  end

  assign bus.ram_en_o   = ram_en_q;
  assign bus.ram_we_o   = ram_we_q;
  assign bus.ram_addr_o = ram_addr_q;
  assign bus.ram_di_o   = ram_di_q;
  assign bus.rd_valid_o = rd_vld_p2;
  assign bus.rd_data_o  = rd_vld_p2 ? bus.ram_do_i : 32'h0;

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: directed tables, hand sequences
// and randomized fills/reads against a word-level reference memory.
module tb_cache_line_fill;

  logic clk_i;
  logic rst_i;

  cache_line_fill_if #(.ADDR_W(10), .LINE_WORDS(8)) bus ();

  cache_line_fill #(.LINE_WORDS(8), .ADDR_W(10)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef logic [7:0] byte_q_t[$];
  typedef struct { logic [9:0] addr; logic [31:0] data; int unsigned cyc; } wr_t;
  typedef struct { int unsigned due; logic [31:0] data; } rd_exp_t;
  typedef struct { bit fill; bit rd; bit exp_ack; bit exp_gnt; } arb_vec_t;
  typedef struct { logic [7:0] b0, b1, b2, b3; logic [31:0] exp_le; logic [31:0] exp_be; } pack_vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ram_do = 32'h0;
  wr_t         wlog[$];
  rd_exp_t     rdq[$];

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010021);
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
`ifdef CACHE_FILL_BSWAP_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Data RAM with one-cycle read latency
  always @(posedge clk_i) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
    end else if (bus.ram_en_o) begin
      if (bus.ram_we_o == 4'hF) ram[bus.ram_addr_o] <= bus.ram_di_o;
      else ram_do <= ram[bus.ram_addr_o];
    end
  end
  assign bus.ram_do_i = ram_do;

  always @(negedge clk_i) begin
    bit exp_v;
    if (bus.ram_en_o && bus.ram_we_o != 4'h0) begin
      check("ram_we_mask", bus.ram_we_o, 4'hF);
      wlog.push_back('{bus.ram_addr_o, bus.ram_di_o, cyc});
    end
    if (bus.fill_done_o) done_cnt++;
    exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
    if (bus.rd_valid_o || exp_v) begin
      check("rd_valid", bus.rd_valid_o, exp_v);
      if (exp_v) begin
        if (bus.rd_valid_o) check("rd_data", bus.rd_data_o, rdq[0].data);
        void'(rdq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.fill_req_i   = 1'b1;
    bus.rd_req_i     = 1'b1;
    bus.byte_valid_i = 1'b1;
    rdq.delete();
    tick();
    tick();
    @(negedge clk_i);
    check("rst_ctrl", {bus.fill_ack_o, bus.fill_done_o, bus.rd_gnt_o, bus.rd_valid_o,
                       bus.byte_ready_o, bus.ram_en_o, bus.ram_we_o}, 32'h0);
    check("rst_ram_addr", bus.ram_addr_o, 32'h0);
    check("rst_ram_di", bus.ram_di_o, 32'h0);
    check("rst_rd_data", bus.rd_data_o, 32'h0);
    bus.fill_req_i   = 1'b0;
    bus.rd_req_i     = 1'b0;
    bus.byte_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  // Starts at posedge+1 in IDLE. Full fills return at the negedge of the
  // fill_done cycle; aborted fills return right after the requested word count.
  task automatic run_fill(input logic [6:0] line, input byte_q_t bytes, input int mode,
                          input bit hold_rd, input int abort_words);
    int idx, k, done_at, nw;
    bit v, done_seen;
    logic [9:0] a;
    wlog.delete();
    bus.fill_req_i  = 1'b1;
    bus.fill_line_i = line;
    @(negedge clk_i);
    check("fill_ack", bus.fill_ack_o, 1);
    check("fill_rd_gnt", bus.rd_gnt_o, 0);
    tick();
    bus.fill_req_i = 1'b0;
    idx = 0;
    k = 0;
    while (idx < 32 && k < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.byte_valid_i = v;
      bus.byte_data_i  = bytes[idx];
      @(negedge clk_i);
      if (hold_rd) check("rd_held_off", bus.rd_gnt_o, 0);
      if (v && bus.byte_ready_o) idx++;
      tick();
      k++;
      if (abort_words > 0 && wlog.size() >= abort_words) break;
    end
    bus.byte_valid_i = 1'b0;
    nw = (abort_words > 0) ? abort_words : 8;
    for (int w = 0; w < nw; w++)
      ref_mem[{line, 3'(w)}] = pack(bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]);
    if (abort_words > 0) return;
    check("fill_bytes_taken", idx, 32);
    done_seen = 1'b0;
    done_at = 0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk_i);
      if (hold_rd) check("rd_held_off_done", bus.rd_gnt_o, 0);
      if (bus.fill_done_o) begin
        done_seen = 1'b1;
        done_at = cyc;
      end else begin
        tick();
      end
    end
    check("fill_done_seen", done_seen, 1);
    check("write_count", wlog.size(), 8);
    for (int w = 0; w < 8 && w < wlog.size(); w++) begin
      a = {line, 3'(w)};
      check("write_addr", wlog[w].addr, a);
      check("write_data", wlog[w].data, ref_mem[a]);
      check("ram_word", ram[a], ref_mem[a]);
    end
    if (wlog.size() > 0) check("done_after_last_write", done_at - wlog[wlog.size()-1].cyc, 1);
  endtask

  task automatic read_burst(input int n);
    logic [9:0] a;
    for (int i = 0; i < n; i++) begin
      a = 10'($urandom);
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = a;
      @(negedge clk_i);
      check("burst_gnt", bus.rd_gnt_o, 1);
      rdq.push_back('{cyc + 2, ref_mem[a]});
      tick();
    end
    bus.rd_req_i = 1'b0;
    repeat (3) tick();
  endtask

  arb_vec_t  arb[4];
  pack_vec_t pk[8];
  byte_q_t   q, q_seq;
  int        done_before;
  logic [6:0] ln;

  initial begin
    rst_i = 1'b1;
    bus.fill_req_i = 1'b0; bus.fill_line_i = '0; bus.byte_valid_i = 1'b0;
    bus.byte_data_i = '0; bus.rd_req_i = 1'b0; bus.rd_addr_i = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);

    arb[0] = '{0, 0, 0, 0};
    arb[1] = '{0, 1, 0, 1};
    arb[2] = '{1, 0, 1, 0};
    arb[3] = '{1, 1, 1, 0};
    pk[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 32'h11223344};
    pk[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE, 32'hDEADBEEF};
    pk[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF, 32'hFF00FF00};
    pk[3] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'hFE7F0180, 32'h80017FFE};
    pk[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h01000000, 32'h00000001};
    pk[5] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5, 32'hA55AC33C};
    pk[6] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412, 32'h12345678};
    pk[7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

    do_reset();

    // IDLE arbitration table
    for (int i = 0; i < 4; i++) begin
      do_reset();
      bus.fill_req_i  = arb[i].fill;
      bus.rd_req_i    = arb[i].rd;
      bus.rd_addr_i   = 10'(100 + i);
      bus.fill_line_i = 7'd1;
      @(negedge clk_i);
      check("arb_ack", bus.fill_ack_o, arb[i].exp_ack);
      check("arb_gnt", bus.rd_gnt_o, arb[i].exp_gnt);
      if (arb[i].exp_gnt) rdq.push_back('{cyc + 2, ref_mem[100 + i]});
      tick();
      bus.fill_req_i = 1'b0;
      bus.rd_req_i   = 1'b0;
      @(negedge clk_i);
      check("arb_byte_ready", bus.byte_ready_o, arb[i].exp_ack);
      repeat (3) tick();
    end
    do_reset();

    // Line 5 with bytes 0x00..0x1F, no stalls
    q_seq.delete();
    for (int i = 0; i < 32; i++) q_seq.push_back(8'(i));
    run_fill(7'd5, q_seq, 0, 0, 0);
`ifdef CACHE_FILL_BSWAP_EN
    check("line5_word0", ram[40], 32'h00010203);
`else
    check("line5_word0", ram[40], 32'h03020100);
`endif
    tick();
    @(negedge clk_i);
    check("fill_done_one_cycle", bus.fill_done_o, 0);
    tick();

    // Same bytes with byte_valid toggling every other cycle
    run_fill(7'd6, q_seq, 1, 0, 0);
    for (int w = 0; w < 8; w++) check("stall_line_match", ram[48 + w], ref_mem[40 + w]);
    tick();

    // Packing table on line 33
    q.delete();
    for (int i = 0; i < 8; i++) begin
      q.push_back(pk[i].b0); q.push_back(pk[i].b1); q.push_back(pk[i].b2); q.push_back(pk[i].b3);
    end
    run_fill(7'd33, q, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
`ifdef CACHE_FILL_BSWAP_EN
      check("pack_table", ram[264 + i], pk[i].exp_be);
`else
      check("pack_table", ram[264 + i], pk[i].exp_le);
`endif
    end
    tick();

    // Read (and simultaneous fill request) held through a whole fill
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = 10'd700;
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
    run_fill(7'd10, q, 2, 1, 0);
    tick();
    @(negedge clk_i);
    check("rd_gnt_after_fill", bus.rd_gnt_o, 1);
    rdq.push_back('{cyc + 2, ref_mem[700]});
    tick();
    bus.rd_req_i = 1'b0;
    repeat (3) tick();
    check("rd_after_fill_returned", rdq.size(), 0);

    // Read granted the cycle before a fill is accepted still returns
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = 10'd300;
    @(negedge clk_i);
    check("pre_fill_gnt", bus.rd_gnt_o, 1);
    rdq.push_back('{cyc + 2, ref_mem[300]});
    tick();
    bus.rd_req_i = 1'b0;
    run_fill(7'd11, q_seq, 0, 0, 0);
    tick();
    check("pre_fill_rd_returned", rdq.size(), 0);

    // Reset while a read is in flight suppresses its return
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = 10'd5;
    @(negedge clk_i);
    check("pending_rd_gnt", bus.rd_gnt_o, 1);
    tick();
    bus.rd_req_i = 1'b0;
    do_reset();

    // Reset after 3 words of a fill, then fill the last line
    done_before = done_cnt;
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
    run_fill(7'd9, q, 0, 0, 3);
    do_reset();
    bus.byte_valid_i = 1'b1;
    @(negedge clk_i);
    check("abort_idle_ready", bus.byte_ready_o, 0);
    repeat (5) tick();
    bus.byte_valid_i = 1'b0;
    check("abort_no_done", done_cnt, done_before);
    for (int w = 0; w < 8; w++) check("abort_ram", ram[72 + w], ref_mem[72 + w]);
    run_fill(7'd127, q_seq, 0, 0, 0);
    if (wlog.size() == 8) begin
      check("line127_first_addr", wlog[0].addr, 10'd1016);
      check("line127_last_addr", wlog[7].addr, 10'd1023);
    end
    tick();

    // Randomized mix of fills and read bursts
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
        ln = 7'($urandom);
        run_fill(ln, q, 2, 0, 0);
        tick();
      end else begin
        read_burst($urandom_range(1, 6));
      end
    end
    read_burst(8);
    check("final_rd_queue_empty", rdq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
